// File: rtl/message_scroller.sv
// message_scroller: sequences a 16-entry combinational message ROM.
// Fetches NUM_DIGITS consecutive characters starting at offset (one per
// clock), commits the window to disp_chars, then waits TICK_DIV enabled
// clocks before stepping offset by +/-1 (mod 16) and fetching again.
//   clk, reset        : clock, synchronous active-high reset
//   enable            : scroll timer runs when high
//   dir               : 0 = forward, 1 = reverse (sampled at the step point)
//   restart           : force offset 0 and refetch immediately
//   char_in           : ROM data for addr (same cycle)
//   addr, offset      : ROM read address, current window start
//   disp_chars        : committed window, digit i at [8i+7:8i]
//   frame_valid       : one-cycle pulse when a new window becomes visible
//   busy              : high while fetching or committing
module message_scroller #(
  parameter int NUM_DIGITS = 6,
  parameter int TICK_DIV   = 25000000
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    enable,
  input  logic                    dir,
  input  logic                    restart,
  input  logic [7:0]              char_in,
  output logic [3:0]              addr,
  output logic [3:0]              offset,
  output logic [8*NUM_DIGITS-1:0] disp_chars,
  output logic                    frame_valid,
  output logic                    busy
);

  localparam int TW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [TW-1:0] TICK_LAST = TW'(TICK_DIV - 1);
  localparam logic [3:0]    IDX_LAST  = 4'(NUM_DIGITS - 1);

  typedef enum logic [1:0] {
    FETCH,
    COMMIT,
    WAIT
  } state_t;

  state_t                  state, state_nx;
  logic [3:0]              idx;
  logic [TW-1:0]           tick_cnt;
  logic [8*NUM_DIGITS-1:0] shadow;
  logic                    last_fetch;
  logic                    terminal;

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= FETCH;
    end else begin
      state <= state_nx;
    end
  end

  always_comb begin
    state_nx   = state;
    last_fetch = (idx == IDX_LAST);
    terminal   = enable && (tick_cnt == TICK_LAST);
    case (state)
      FETCH:   if (last_fetch) state_nx = COMMIT;
      COMMIT:  state_nx = WAIT;
      WAIT:    if (terminal) state_nx = FETCH;
      default: state_nx = FETCH;
    endcase
    if (restart) begin
      state_nx = FETCH;
    end
  end

  always_comb begin
    addr = offset;
    if (state == FETCH) begin
      addr = offset + idx;
    end
    // Gated by reset so busy reads low while reset is held.
    busy = (state != WAIT) && !reset;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      idx         <= '0;
      offset      <= '0;
      tick_cnt    <= '0;
      shadow      <= {NUM_DIGITS{8'h20}};
      disp_chars  <= {NUM_DIGITS{8'h20}};
      frame_valid <= 1'b0;
    end else begin
      frame_valid <= 1'b0;
      if (restart) begin
        idx      <= '0;
        offset   <= '0;
        tick_cnt <= '0;
      end else begin
        case (state)
          FETCH: begin
            for (int unsigned i = 0; i < unsigned'(NUM_DIGITS); i++) begin
              if (idx == 4'(i)) begin
                shadow[8*i +: 8] <= char_in;
              end
            end
            idx <= last_fetch ? 4'd0 : idx + 4'd1;
          end
          COMMIT: begin
            disp_chars  <= shadow;
            frame_valid <= 1'b1;
            tick_cnt    <= '0;
          end
          WAIT: begin
            if (terminal) begin
              offset   <= dir ? offset - 4'd1 : offset + 4'd1;
              tick_cnt <= '0;
            end else if (enable) begin
              tick_cnt <= tick_cnt + TW'(1);
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_message_scroller.sv
module tb_message_scroller;

  localparam int N  = 6;
  localparam int TD = 4;

  logic           clk = 1'b0;
  logic           reset, enable, dir, restart;
  logic [7:0]     char_in;
  logic [3:0]     addr, offset;
  logic [8*N-1:0] disp_chars;
  logic           frame_valid, busy;

  int checks = 0;
  int errors = 0;

  logic [7:0] rom [16] = '{8'h27, 8'h27, 8'h20, 8'h48, 8'h45, 8'h4C, 8'h4C, 8'h4F,
                           8'h20, 8'h43, 8'h4C, 8'h49, 8'h50, 8'h2E, 8'h27, 8'h27};

  typedef struct packed {
    logic [8*N-1:0] disp;
    logic [3:0]     off;
  } frame_t;

  frame_t exp_q[$];

  message_scroller #(.NUM_DIGITS(N), .TICK_DIV(TD)) dut (
    .clk(clk), .reset(reset), .enable(enable), .dir(dir), .restart(restart),
    .char_in(char_in), .addr(addr), .offset(offset), .disp_chars(disp_chars),
    .frame_valid(frame_valid), .busy(busy)
  );

  always #5 clk = ~clk;
  assign char_in = rom[addr];

  function automatic frame_t win(input int off);
    frame_t f;
    for (int i = 0; i < N; i++) f.disp[8*i +: 8] = rom[(off + i) % 16];
    f.off = 4'(off);
    return f;
  endfunction

  // Scoreboard: every committed frame must match the oldest expected window.
  always @(negedge clk) begin : monitor
    frame_t e;
    if (frame_valid) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL frame_unexpected: got disp=%h offset=%0d, required no frame", disp_chars, offset);
      end else begin
        e = exp_q.pop_front();
        if (disp_chars !== e.disp || offset !== e.off) begin
          errors++;
          $display("FAIL frame_content: got disp=%h offset=%0d, required disp=%h offset=%0d",
                   disp_chars, offset, e.disp, e.off);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic test_reset();
    reset = 1'b1; enable = 1'b0; dir = 1'b0; restart = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    checks++; if (addr !== 4'd0) begin errors++; $display("FAIL reset_addr: got %0d, required 0", addr); end
    checks++; if (offset !== 4'd0) begin errors++; $display("FAIL reset_offset: got %0d, required 0", offset); end
    checks++; if (disp_chars !== {N{8'h20}}) begin errors++; $display("FAIL reset_disp: got %h, required %h", disp_chars, {N{8'h20}}); end
    checks++; if (frame_valid !== 1'b0) begin errors++; $display("FAIL reset_fv: got %b, required 0", frame_valid); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b, required 0", busy); end
  endtask

  task automatic test_first_frame();
    int nfv = 0;
    int first = -1;
    exp_q.push_back(win(0));
    @(negedge clk);
    reset = 1'b0;
    for (int c = 0; c < 20; c++) begin
      #1;
      if (c < N) begin
        checks++;
        if (addr !== 4'(c)) begin errors++; $display("FAIL first_addr[%0d]: got %0d, required %0d", c, addr, c); end
      end
      if (c == 0) begin
        checks++;
        if (busy !== 1'b1) begin errors++; $display("FAIL first_busy: got %b, required 1", busy); end
      end
      if (frame_valid) begin
        nfv++;
        if (first < 0) first = c;
      end
      @(negedge clk);
    end
    checks++; if (nfv != 1) begin errors++; $display("FAIL first_frame_count: got %0d, required 1", nfv); end
    checks++; if (first != N + 1) begin errors++; $display("FAIL first_frame_cycle: got %0d, required %0d", first, N + 1); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL first_idle_busy: got %b, required 0", busy); end
  endtask

  task automatic test_forward();
    int nfv = 0;
    int f1 = -1;
    int f2 = -1;
    bit wrap = 1'b0;
    reset = 1'b1;
    repeat (2) @(negedge clk);
    for (int k = 0; k < 16; k++) exp_q.push_back(win(k));
    @(negedge clk);
    reset = 1'b0; enable = 1'b1; dir = 1'b0;
    for (int c = 0; c < 250 && nfv < 16; c++) begin
      #1;
      if (busy && offset == 4'd14 && addr == 4'd0) wrap = 1'b1;
      if (frame_valid) begin
        nfv++;
        if (nfv == 1) f1 = c;
        if (nfv == 2) f2 = c;
        if (nfv == 16) enable = 1'b0;
      end
      @(negedge clk);
    end
    checks++; if (nfv != 16) begin errors++; $display("FAIL fwd_frames: got %0d, required 16", nfv); end
    checks++; if (f1 != N + 1) begin errors++; $display("FAIL fwd_first_cycle: got %0d, required %0d", f1, N + 1); end
    checks++; if (f2 - f1 != TD + N + 1) begin errors++; $display("FAIL fwd_period: got %0d, required %0d", f2 - f1, TD + N + 1); end
    checks++; if (!wrap) begin errors++; $display("FAIL fwd_addr_wrap: got no addr 0 at offset 14, required wrap"); end
    checks++; if (offset !== 4'd15) begin errors++; $display("FAIL fwd_final_offset: got %0d, required 15", offset); end
  endtask

  task automatic test_reverse();
    int c = 0;
    bit got = 1'b0;
    exp_q.push_back(win(0));
    restart = 1'b1;
    while (!got && c < 30) begin
      @(negedge clk);
      restart = 1'b0;
      c++;
      if (frame_valid) got = 1'b1;
    end
    checks++; if (!got || c != N + 2) begin errors++; $display("FAIL restart_latency: got %0d (seen=%b), required %0d", c, got, N + 2); end
    exp_q.push_back(win(15));
    dir = 1'b1; enable = 1'b1;
    c = 0; got = 1'b0;
    while (!got && c < 30) begin
      @(negedge clk);
      c++;
      if (frame_valid) got = 1'b1;
    end
    enable = 1'b0;
    checks++; if (!got || c != TD + N + 1) begin errors++; $display("FAIL rev_period: got %0d (seen=%b), required %0d", c, got, TD + N + 1); end
    #1;
    checks++; if (offset !== 4'd15) begin errors++; $display("FAIL rev_offset: got %0d, required 15", offset); end
  endtask

  task automatic test_restart_mid_fetch();
    int c = 0;
    bit got = 1'b0;
    for (int k = 0; k < 3; k++) exp_q.push_back(win(k));
    dir = 1'b0; enable = 1'b1;
    while (!(busy && offset == 4'd3) && c < 100) begin
      @(negedge clk);
      #1;
      c++;
    end
    checks++; if (c >= 100) begin errors++; $display("FAIL rs_reach_offset3: got timeout, required FETCH at offset 3"); end
    repeat (2) @(negedge clk);
    #1;
    checks++; if (addr !== 4'd5) begin errors++; $display("FAIL rs_third_fetch_addr: got %0d, required 5", addr); end
    restart = 1'b1; enable = 1'b0;
    exp_q.push_back(win(0));
    c = 0;
    while (!got && c < 30) begin
      @(negedge clk);
      restart = 1'b0;
      c++;
      #1;
      if (c == 1) begin
        checks++;
        if (addr !== 4'd0 || offset !== 4'd0) begin
          errors++; $display("FAIL rs_refetch: got addr=%0d offset=%0d, required 0 0", addr, offset);
        end
      end
      if (frame_valid) got = 1'b1;
    end
    checks++; if (!got || c != N + 2) begin errors++; $display("FAIL rs_latency: got %0d (seen=%b), required %0d", c, got, N + 2); end
  endtask

  task automatic test_enable_gap();
    int c = 0;
    bit got = 1'b0;
    exp_q.push_back(win(1));
    exp_q.push_back(win(2));
    enable = 1'b1;
    while (!got && c < 30) begin
      @(negedge clk);
      c++;
      if (frame_valid) got = 1'b1;
    end
    checks++; if (!got) begin errors++; $display("FAIL gap_first_frame: got timeout, required frame"); end
    @(negedge clk);
    enable = 1'b0;
    repeat (5) @(negedge clk);
    #1;
    checks++; if (offset !== 4'd1) begin errors++; $display("FAIL gap_offset_frozen: got %0d, required 1", offset); end
    enable = 1'b1;
    c = 6; got = 1'b0;
    while (!got && c < 40) begin
      @(negedge clk);
      c++;
      if (frame_valid) got = 1'b1;
    end
    checks++; if (!got || c != TD + N + 1 + 5) begin errors++; $display("FAIL gap_period: got %0d (seen=%b), required %0d", c, got, TD + N + 6); end
  endtask

  task automatic test_reset_mid_fetch();
    int c = 0;
    bit got = 1'b0;
    while (!busy && c < 30) begin
      @(negedge clk);
      #1;
      c++;
    end
    checks++; if (!busy) begin errors++; $display("FAIL rm_reach_fetch: got timeout, required FETCH"); end
    repeat (2) @(negedge clk);
    reset = 1'b1; enable = 1'b0;
    @(negedge clk);
    #1;
    checks++; if (disp_chars !== {N{8'h20}}) begin errors++; $display("FAIL rm_disp: got %h, required %h", disp_chars, {N{8'h20}}); end
    checks++; if (offset !== 4'd0) begin errors++; $display("FAIL rm_offset: got %0d, required 0", offset); end
    checks++; if (busy !== 1'b0 || frame_valid !== 1'b0) begin errors++; $display("FAIL rm_ctrl: got busy=%b fv=%b, required 0 0", busy, frame_valid); end
    exp_q.push_back(win(0));
    @(negedge clk);
    reset = 1'b0;
    c = 0;
    while (!got && c < 20) begin
      #1;
      if (frame_valid) got = 1'b1;
      else begin
        @(negedge clk);
        c++;
      end
    end
    checks++; if (!got || c != N + 1) begin errors++; $display("FAIL rm_refill_cycle: got %0d (seen=%b), required %0d", c, got, N + 1); end
  endtask

  initial begin
    test_reset();
    test_first_frame();
    test_forward();
    test_reverse();
    test_restart_mid_fetch();
    test_enable_gap();
    test_reset_mid_fetch();
    repeat (3) @(negedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      errors++; $display("FAIL frames_outstanding: got %0d pending, required 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
